fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle MIPS core.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers fetched words in a small prefetch FIFO and presents them to the core over a valid/ready interface.
- Redirects the fetch stream on branch/jump (redirect) and discards any in-flight response.

Parameters:
DEPTH, 2, prefetch FIFO entries (power of 2, >= 2)
RESET_PC, 32'h0000_3000, first fetch address after reset

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  read request; held high with stable imem_addr until imem_ack
imem_addr  output  32  word-aligned fetch address
imem_ack  input  1  read completes in the cycle with imem_req && imem_ack
imem_rdata  input  32  instruction word, valid with imem_ack
inst_valid  output  1  FIFO head valid to core
inst_ready  input  1  core consumes head (pop when inst_valid && inst_ready)
inst  output  32  head instruction word (0 when empty)
inst_pc  output  32  PC of head instruction (0 when empty)
redirect  input  1  branch/jump taken this cycle
redirect_pc  input  32  new fetch target; bits [1:0] ignored (forced 0)

Behaviour:
- Reset (reset low, async):
  - fetch_pc=RESET_PC, FIFO empty, state=IDLE, pending_pc=0.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0.
- States:
  - IDLE: no request.
  - REQ: request for fetch_pc outstanding.
  - DISCARD: old request outstanding whose data is dropped.
- imem_req = (state==REQ || state==DISCARD); imem_addr = fetch_pc. Both are stable while waiting for ack.
- next_count = count + (ack accepted into FIFO) - pop. At most one outstanding request.
- IDLE -> REQ when next_count < DEPTH. First request is in the first cycle after reset deasserts.
- REQ with ack, no redirect:
  - Push {fetch_pc, imem_rdata}; fetch_pc += 4.
  - Stay REQ if next_count < DEPTH, else IDLE.
  - Back-to-back acks give 1 instruction/cycle.
- fetch_pc wraps 32'hFFFF_FFFC + 4 -> 0.
- Latency: ack at cycle N -> inst_valid/inst at cycle N+1. No bypass.
- redirect (any state):
  - FIFO flushed at the edge; inst_valid is combinationally masked to 0 while redirect is high, so no pop is counted.
  - IDLE, or REQ with ack the same cycle: data dropped, fetch_pc <= redirect_pc, go to REQ.
  - REQ without ack: pending_pc <= redirect_pc, go to DISCARD.
  - DISCARD: pending_pc <= redirect_pc (latest wins).
- DISCARD with ack: data dropped, fetch_pc <= pending_pc, go to REQ.
- Full FIFO: no request is issued. Pop and ack in the same cycle on a full FIFO is impossible by construction, because no request is issued when next_count would reach DEPTH.
- Empty FIFO: pop ignored.
- Reset mid-request: the response is not tracked. Memory must drop the request when reset is applied.

Optional Feature:
- Macro FETCH_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles (32).
  - Increments every cycle where inst_ready=1 and inst_valid=0, outside reset and redirect.
  - Saturates at 32'hFFFF_FFFF; reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package mips_defs:
  - RESET_PC default, INSTR_W=32, ADDR_W=32.
  - Fetch state encoding (IDLE=2'd0, REQ=2'd1, DISCARD=2'd2).
- Sub-module fetch_fifo:
  - Parameterised DEPTH, synchronous push/pop/flush, async active-low reset.
  - Count output; head data is 0 when empty.

Test Plan:
- Zero-wait memory, imem_ack tied 1, inst_ready=1 -> addresses 0x3000, 0x3004, 0x3008 on consecutive cycles; inst_pc 0x3000 appears the cycle after the first ack; one instruction per cycle thereafter.
- inst_ready=0, ack always 1 -> exactly DEPTH=2 acks (0x3000, 0x3004), imem_req then 0. Raising inst_ready restarts fetch at 0x3008 with no lost or duplicate PCs.
- Memory with 3-cycle ack latency, redirect to 0x4002 during the wait -> the old response is dropped, the next imem_addr is 0x4000, and the first inst_pc delivered is 0x4000.
- Two redirects (0x5000, then 0x6000) before the delayed ack -> only 0x6000 is fetched; 0x5000 is never requested.
- redirect in the same cycle as an ack with the FIFO holding 0x3000 -> FIFO empty next cycle, imem_addr equals the redirect target, and the acked word is never delivered.
- Assert reset low while in REQ -> imem_req, inst_valid and inst fall to 0 immediately. After release, the first request is to 0x3000. With FETCH_STALL_CNT_EN, stall_cycles returns to 0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the MIPS front end: widths, reset PC and fetch state encoding.
package mips_defs;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StDiscard = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, word} entries with synchronous push/pop/flush; head reads 0 when empty.
module fetch_fifo
  import mips_defs::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack memory port, prefetch FIFO and redirect handling.
// Optional stall cycle counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit
  import mips_defs::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned NC_W  = CNT_W + 1;

  fetch_state_e     state_q;
  logic [31:0]      fetch_pc_q, pending_pc_q;
  logic [31:0]      redirect_tgt;
  logic [CNT_W-1:0] count;
  logic [NC_W-1:0]  next_count;
  logic             push, pop, room;
  fetch_entry_t     head, wdata;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // Redirect masks the head so the flushed entry can never be consumed.
  assign inst_valid = (count != '0) && !redirect;
  assign pop        = inst_valid && inst_ready;
  assign push       = (state_q == StReq) && imem_ack && !redirect;
  assign next_count = {1'b0, count} + NC_W'(push) - NC_W'(pop);
  assign room       = next_count < NC_W'(DEPTH);

  assign wdata = '{pc: fetch_pc_q, word: imem_rdata};

  fetch_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(redirect),
    .wdata(wdata),
    .head (head),
    .count(count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (redirect) begin
            fetch_pc_q <= redirect_tgt;
            state_q    <= StReq;
          end else if (room) begin
            state_q <= StReq;
          end
        end
        StReq: begin
          if (redirect) begin
            if (imem_ack) begin
              fetch_pc_q <= redirect_tgt;
            end else begin
              pending_pc_q <= redirect_tgt;
              state_q      <= StDiscard;
            end
          end else if (imem_ack) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
            if (!room) state_q <= StIdle;
          end
        end
        StDiscard: begin
          // A redirect arriving with the stale ack still wins over the pending target.
          if (imem_ack) begin
            fetch_pc_q <= redirect ? redirect_tgt : pending_pc_q;
            state_q    <= StReq;
          end else if (redirect) begin
            pending_pc_q <= redirect_tgt;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req  = (state_q == StReq) || (state_q == StDiscard);
  assign imem_addr = fetch_pc_q;
  assign inst      = head.word;
  assign inst_pc   = head.pc;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (inst_ready && !inst_valid && !redirect && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a queue model.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
`ifdef FETCH_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  int          n_total = 0;
  int          n_bad   = 0;
  ent_t        mq[$];
  logic        m_req, m_stale;
  logic [31:0] m_pc, m_stale_addr, m_stall;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_req        = 1'b0;
    m_stale      = 1'b0;
    m_pc         = RESET_PC;
    m_stale_addr = '0;
    m_stall      = '0;
  endtask

  // Drive one cycle's inputs, check outputs against the model, then advance the model.
  task automatic cycle(input logic a, input logic r, input logic rd, input logic [31:0] rpc);
    logic push, pop;
    imem_ack    = a;
    inst_ready  = r;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rdata  = mem_word(imem_addr);
    #1;
    check_eq("imem_req", imem_req, m_req);
    if (m_req) check_eq("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
    check_eq("inst_valid", inst_valid, (mq.size() > 0) && !rd);
    if (mq.size() == 0) begin
      check_eq("inst_pc_empty", inst_pc, 32'h0);
      check_eq("inst_empty", inst, 32'h0);
    end else if (!rd) begin
      check_eq("inst_pc", inst_pc, mq[0].pc);
      check_eq("inst", inst, mq[0].word);
    end
`ifdef FETCH_STALL_CNT_EN
    check_eq("stall_cycles", stall_cycles, m_stall);
    if (r && (mq.size() == 0) && !rd && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
`endif
    push = m_req && a && !m_stale && !rd;
    pop  = (mq.size() > 0) && !rd && r;
    if (rd) begin
      mq.delete();
    end else begin
      if (pop) mq.delete(0);
      if (push) mq.push_back('{m_pc, mem_word(m_pc)});
    end
    if (rd) begin
      if (m_req && !a) begin
        if (!m_stale) m_stale_addr = m_pc;
        m_stale = 1'b1;
      end else begin
        m_stale = 1'b0;
      end
      m_pc  = {rpc[31:2], 2'b00};
      m_req = 1'b1;
    end else if (m_req && a) begin
      if (m_stale) begin
        m_stale = 1'b0;
      end else begin
        m_pc  = m_pc + 32'd4;
        m_req = mq.size() < DEPTH;
      end
    end else if (!m_req) begin
      m_req = mq.size() < DEPTH;
    end
  endtask

  task automatic step(input logic a, input logic r, input logic rd, input logic [31:0] rpc);
    @(negedge clock);
    cycle(a, r, rd, rpc);
  endtask

  task automatic rand_phase(input int n, input int ack_pct, input int rdy_pct, input int rd_pct);
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step($urandom_range(0, 99) < ack_pct, $urandom_range(0, 99) < rdy_pct,
           $urandom_range(0, 99) < rd_pct, tgt);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop before any clock edge.
  task automatic mid_reset();
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_imem_req", imem_req, 1'b0);
    check_eq("rst_inst_valid", inst_valid, 1'b0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_STALL_CNT_EN
    check_eq("rst_stall_cycles", stall_cycles, 32'h0);
`endif
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    reset       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #1;
    check_eq("init_imem_req", imem_req, 1'b0);
    check_eq("init_inst_valid", inst_valid, 1'b0);
    check_eq("init_inst_pc", inst_pc, 32'h0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Zero-wait memory, core always ready.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // Core stalls: FIFO fills, requests stop, then resume.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect during a slow response.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_4002);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Two redirects before the stale ack: latest target wins.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_5000);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_6000);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with an ack while the FIFO holds 0x3000.
    mid_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_7000);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset while a request is outstanding.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    mid_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    rand_phase(400, 100, 70, 5);
    rand_phase(400, 35, 60, 8);
    rand_phase(400, 60, 30, 3);
    mid_reset();
    rand_phase(400, 50, 50, 15);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
